// File: rtl/simple_unsigned_multiplier.sv
// Purpose : WIDTH-stage pipelined shift-and-add unsigned multiplier, out = ina * inb.
// Latency : operands sampled on edge k are on out right after edge k+WIDTH-1.
// Backpressure: none; a new operand pair is accepted on every rising edge, with no stall.
//
// Ports:
//   ina  [WIDTH-1:0]   unsigned multiplicand, sampled every rising edge of clk
//   inb  [WIDTH-1:0]   unsigned multiplier, sampled every rising edge of clk
//   clk                single clock, rising-edge only
//   out  [2*WIDTH-1:0] unsigned product, driven straight from the last pipeline stage
//   rst                asynchronous active-high reset; clears every stage and operand copy
module simple_unsigned_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]   ina,
  input  logic [WIDTH-1:0]   inb,
  input  logic               clk,
  output logic [2*WIDTH-1:0] out,
  input  logic               rst
);

  localparam int PW = 2 * WIDTH;

  // partial_sum[i] holds the sum of the multiplicand shifted by every set bit
  // among multiplier bits 0..i, for the operand pair that entered i edges ago.
  logic [PW-1:0]    partial_sum   [WIDTH];
  logic [PW-1:0]    partial_sum_d [WIDTH];

  // Operand copies travelling alongside stages 0..WIDTH-2. The final stage
  // produces the finished product and has no later stage to feed, so it
  // needs no copy of its own.
  logic [WIDTH-1:0] op_a_q [WIDTH-1];
  logic [WIDTH-1:0] op_a_d [WIDTH-1];
  logic [WIDTH-1:0] op_b_q [WIDTH-1];
  logic [WIDTH-1:0] op_b_d [WIDTH-1];

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      partial_sum_d[i] = '0;
    end
    for (int i = 0; i < WIDTH - 1; i++) begin
      op_a_d[i] = '0;
      op_b_d[i] = '0;
    end

    // Stage 0 works straight from the ports.
    partial_sum_d[0] = inb[0] ? {{WIDTH{1'b0}}, ina} : '0;
    op_a_d[0]        = ina;
    op_b_d[0]        = inb;

    // Stage i adds the multiplicand shifted by i when multiplier bit i is set.
    // Operands come from the copy registered next to the previous stage's
    // partial sum, so every pair stays aligned with its own running sum.
    for (int i = 1; i < WIDTH; i++) begin
      partial_sum_d[i] = partial_sum[i-1] +
                         (op_b_q[i-1][i] ? ({{WIDTH{1'b0}}, op_a_q[i-1]} << i) : '0);
    end

    for (int i = 1; i < WIDTH - 1; i++) begin
      op_a_d[i] = op_a_q[i-1];
      op_b_d[i] = op_b_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        partial_sum[i] <= '0;
      end
      for (int i = 0; i < WIDTH - 1; i++) begin
        op_a_q[i] <= '0;
        op_b_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        partial_sum[i] <= partial_sum_d[i];
      end
      for (int i = 0; i < WIDTH - 1; i++) begin
        op_a_q[i] <= op_a_d[i];
        op_b_q[i] <= op_b_d[i];
      end
    end
  end

  // No output register: the last stage already holds the finished product.
  assign out = partial_sum[WIDTH-1];

endmodule

// File: tb/tb_simple_unsigned_multiplier.sv
module tb_simple_unsigned_multiplier;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   ina;
  logic [W-1:0]   inb;
  logic [2*W-1:0] out;

  simple_unsigned_multiplier #(.WIDTH(W)) dut (
    .ina (ina),
    .inb (inb),
    .clk (clk),
    .out (out),
    .rst (rst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } pair_t;

  logic [2*W-1:0] exp_q [$];   // expected products, one per sampling edge
  pair_t          pq    [$];   // recent sampled pairs, newest at the back

  int total = 0;
  int bad   = 0;

  function automatic logic [2*W-1:0] golden(input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return p[2*W-1:0];
  endfunction

  // Value of stage i: multiplicand times the multiplier reduced to its low i+1 bits.
  function automatic logic [2*W-1:0] golden_partial(input logic [W-1:0] a,
                                                    input logic [W-1:0] b, input int i);
    longint unsigned p;
    longint unsigned m;
    m = longint'(b) % (64'd1 << (i + 1));
    p = longint'(a) * m;
    return p[2*W-1:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Sampler: whatever sits on the inputs at a rising edge (outside reset) is
  // an issued operand pair; its product goes into the scoreboard.
  always @(posedge clk) begin
    if (!rst) begin
      pair_t p;
      p.a = ina;
      p.b = inb;
      exp_q.push_back(golden(ina, inb));
      pq.push_back(p);
      if (pq.size() > W) void'(pq.pop_front());
    end
  end

  // Monitor: once W pairs have been sampled since reset, each edge delivers
  // the oldest outstanding product; before that the output must read zero.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() >= W) begin
      check("product", 64'(out), 64'(exp_q.pop_front()));
    end else begin
      check("fill_zero", 64'(out), 64'd0);
    end
    for (int i = 3; i < W - 1; i += 5) begin
      if (pq.size() > i) begin
        pair_t p;
        p = pq[pq.size() - 1 - i];
        check($sformatf("partial_sum[%0d]", i), 64'(dut.partial_sum[i]),
              64'(golden_partial(p.a, p.b, i)));
      end
    end
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    ina = a;
    inb = b;
  endtask

  task automatic drive_random(input int n);
    for (int k = 0; k < n; k++) begin
      drive(W'($urandom), W'($urandom));
    end
  endtask

  initial begin
    logic [2*W-1:0] ps_or;

    rst = 1'b1;
    ina = '0;
    inb = '0;
    repeat (3) @(negedge clk);

    // Held 3 x 5 right after reset: zeros for 15 edges, then 15.
    rst = 1'b0;
    ina = 16'd3;
    inb = 16'd5;
    repeat (16) @(negedge clk);

    // Extremes, zero and identity operands.
    drive(16'hFFFF, 16'hFFFF);
    drive(16'd0, 16'd12345);
    drive(16'd1, 16'd40000);
    drive(16'd40000, 16'd1);
    drive(16'hFFFF, 16'd0);
    drive(16'h8000, 16'h8000);

    // Streaming random pairs, one per cycle.
    drive_random(200);

    // Inputs toggling between edges: only the values present at the rising
    // edge may be used; the sampler records exactly those.
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #2;
      ina = W'($urandom);
      inb = W'($urandom);
      @(negedge clk);
      ina = W'($urandom);
      inb = W'($urandom);
      #2;
      ina = W'($urandom);
      inb = W'($urandom);
    end

    // Let the pipeline drain its checks, then 8 pairs in flight and an
    // asynchronous reset between edges.
    drive_random(20);
    drive_random(8);
    @(negedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    pq.delete();
    #1;
    check("async_rst_out", 64'(out), 64'd0);
    ps_or = '0;
    for (int i = 0; i < W; i++) ps_or = ps_or | dut.partial_sum[i];
    check("async_rst_partial_sums", 64'(ps_or), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ina = 16'd1234;
    inb = 16'd4321;
    drive_random(40);

    // Short reset pulse with no clock edge inside it.
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    pq.delete();
    #1;
    check("pulse_rst_out", 64'(out), 64'd0);
    #1;
    rst = 1'b0;
    drive(16'd777, 16'd999);
    drive_random(30);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
